// File: rtl/nios_led1_led_sequencer.sv
// LED pattern sequencer for the nios_led1 2-bit PIO.
// The CPU programs a 4-step pattern, a step period and a run mode through
// an Avalon-MM slave. The block then writes one step per period to the PIO
// s1 port through a write-only Avalon-MM master.
module nios_led1_led_sequencer #(
  parameter int                    PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0]   DEFAULT_PERIOD = 24'd4999999
) (
  input  logic        clk,
  input  logic        reset_n,
  // slave port (CPU side)
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  // master port (PIO s1 side)
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t              state;
  logic                en;
  logic                oneshot;
  logic                irq_en;
  logic                done;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic [7:0]          pattern;
  logic [1:0]          step;

  logic                wr_en;
  logic                busy;
  logic                wdata_unused;

  assign wr_en = chipselect & ~write_n;
  assign busy  = (state != S_IDLE);

  // Only the low bits of some registers are stored; upper write data is ignored.
  assign wdata_unused = ^writedata;

  // Register file and sequencer FSM. FSM updates come last so that a hardware
  // DONE set or EN clear wins over a software write in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      en      <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      period  <= DEFAULT_PERIOD;
      counter <= '0;
      pattern <= '0;
      step    <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          2'd0: begin
            en      <= writedata[0];
            oneshot <= writedata[1];
            irq_en  <= writedata[2];
          end
          2'd1: period  <= writedata[PERIOD_W-1:0];
          2'd2: pattern <= writedata[7:0];
          2'd3: if (writedata[0]) done <= 1'b0;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (en) begin
            step  <= 2'd0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // PERIOD is sampled here, so mid-run edits apply at the next load
          counter <= period;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (counter != '0) begin
            counter <= counter - PERIOD_W'(1);
          end else if (step == 2'd3 && oneshot) begin
            done  <= 1'b1;
            en    <= 1'b0;
            state <= S_IDLE;
          end else begin
            step  <= step + 2'd1;
            state <= S_WRITE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Master strobe is decoded straight from the state flop, so an async reset
  // drops it immediately and PATTERN edits show up at the very next WRITE.
  assign m_address    = 2'd0;
  assign m_chipselect = (state == S_WRITE);
  assign m_write_n    = (state != S_WRITE);
  assign m_writedata  = (state == S_WRITE) ? {30'd0, pattern[{step, 1'b0} +: 2]} : 32'd0;

  assign irq = done & irq_en;

  // Zero-wait-state read mux; unused bits read 0.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {28'd0, busy, irq_en, oneshot, en};
      2'd1: readdata = 32'(period);
      2'd2: readdata = {24'd0, pattern};
      2'd3: readdata = {26'd0, step, 3'd0, done};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_nios_led1_led_sequencer.sv
// Directed bench for nios_led1_led_sequencer: a register vector table plus
// hand-written sequences for start latency, spacing, one-shot, stop and reset.
module tb_nios_led1_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  nios_led1_led_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; logic [1:0] addr; } strobe_t;
  strobe_t sq[$];

  // master write monitor, sampled mid-cycle
  always @(negedge clk)
    if (reset_n && m_chipselect && !m_write_n)
      sq.push_back('{cyc, m_writedata, m_address});

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic chk_strobe(input string nm, input int t, input int i,
                            input int ecyc, input logic [31:0] ed);
    if (sq.size() > i) begin
      chk({nm, " cyc"},  32'(sq[i].cyc - t), 32'(ecyc));
      chk({nm, " data"}, sq[i].data, ed);
      chk({nm, " addr"}, 32'(sq[i].addr), 32'd0);
    end else begin
      chk({nm, " present"}, 32'd0, 32'd1);
    end
  endtask

  typedef struct { logic is_wr; logic [1:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;
  vec_t vt[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int t;

    vt[0]  = '{1'b0, 2'd0, 32'h0,          32'h0};
    vt[1]  = '{1'b0, 2'd1, 32'h0,          32'd4999999};
    vt[2]  = '{1'b0, 2'd2, 32'h0,          32'h0};
    vt[3]  = '{1'b0, 2'd3, 32'h0,          32'h0};
    vt[4]  = '{1'b1, 2'd1, 32'h0012_3456,  32'h0};
    vt[5]  = '{1'b0, 2'd1, 32'h0,          32'h0012_3456};
    vt[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF,  32'h0};
    vt[7]  = '{1'b0, 2'd1, 32'h0,          32'h00FF_FFFF};
    vt[8]  = '{1'b1, 2'd2, 32'hABCD_01FF,  32'h0};
    vt[9]  = '{1'b0, 2'd2, 32'h0,          32'h0000_00FF};
    vt[10] = '{1'b1, 2'd0, 32'hFFFF_FFFE,  32'h0};
    vt[11] = '{1'b0, 2'd0, 32'h0,          32'h0000_0006};
    vt[12] = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'h0};
    vt[13] = '{1'b0, 2'd3, 32'h0,          32'h0};
    vt[14] = '{1'b1, 2'd0, 32'h0,          32'h0};
    vt[15] = '{1'b0, 2'd0, 32'h0,          32'h0};

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (2) @(negedge clk);
    chk("rst m_chipselect", 32'(m_chipselect), 32'd0);
    chk("rst m_write_n",    32'(m_write_n),    32'd1);
    chk("rst m_writedata",  m_writedata,       32'd0);
    chk("rst m_address",    32'(m_address),    32'd0);
    chk("rst irq",          32'(irq),          32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // register table: reset values, masking, readback; EN never set
    for (int i = 0; i < 16; i++) begin
      if (vt[i].is_wr) wr(vt[i].a, vt[i].d);
      else begin
        rd(vt[i].a, r);
        chk($sformatf("vec%0d read", i), r, vt[i].exp);
      end
    end
    chk("vec idle strobe", 32'(sq.size()), 32'd0);
    chk("vec irq", 32'(irq), 32'd0);

    // free-running: PERIOD=2, PATTERN=E4, EN rewritten mid-run has no effect
    wr(2'd1, 32'd2); wr(2'd2, 32'hE4);
    sq.delete();
    t = cyc;
    wr(2'd0, 32'h1);
    wait_to(t + 8);
    wr(2'd0, 32'h1);
    wait_to(t + 20);
    for (int i = 0; i < 5; i++)
      chk_strobe($sformatf("run s%0d", i), t, i, 2 + 4 * i, 32'(i % 4));
    rd(2'd0, r); chk("run ctrl busy", r, 32'h9);
    wr(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    rd(2'd0, r); chk("run stop ctrl", r, 32'h0);

    // one-shot: PERIOD=0, PATTERN=1B, IRQ enabled
    wr(2'd1, 32'd0); wr(2'd2, 32'h1B);
    sq.delete();
    t = cyc;
    wr(2'd0, 32'h7);
    wait_to(t + 9);
    chk("os irq before", 32'(irq), 32'd0);
    rd(2'd0, r); chk("os ctrl before", r, 32'hF);
    @(negedge clk);
    chk("os irq after", 32'(irq), 32'd1);
    rd(2'd0, r); chk("os ctrl after", r, 32'h6);
    rd(2'd3, r); chk("os status", r, 32'h31);
    repeat (10) @(negedge clk);
    chk("os strobe count", 32'(sq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_strobe($sformatf("os s%0d", i), t, i, 2 + 2 * i, 32'(3 - i));
    wr(2'd3, 32'h1);
    chk("os irq cleared", 32'(irq), 32'd0);
    rd(2'd3, r); chk("os status cleared", r, 32'h30);

    // stop during WRITE: the strobe completes, nothing follows
    wr(2'd1, 32'd5); wr(2'd2, 32'hE4);
    sq.delete();
    t = cyc;
    wr(2'd0, 32'h1);
    wait_to(t + 2);
    chk("stop in write", 32'(m_chipselect), 32'd1);
    wr(2'd0, 32'h0);
    repeat (50) @(negedge clk);
    chk("stop strobe count", 32'(sq.size()), 32'd1);
    rd(2'd0, r); chk("stop ctrl", r, 32'h0);
    chk("stop m_writedata", m_writedata, 32'd0);

    // PATTERN changed between steps, then async reset during a WRITE
    wr(2'd1, 32'd3); wr(2'd2, 32'h00);
    sq.delete();
    t = cyc;
    wr(2'd0, 32'h1);
    wait_to(t + 4);
    wr(2'd2, 32'hFF);
    wait_to(t + 8);
    chk_strobe("pat s0", t, 0, 2, 32'd0);
    chk_strobe("pat s1", t, 1, 7, 32'd3);
    wait_to(t + 12);
    chk("rst2 pre write", 32'(m_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst2 m_chipselect", 32'(m_chipselect), 32'd0);
    chk("rst2 m_write_n",    32'(m_write_n),    32'd1);
    chk("rst2 m_writedata",  m_writedata,       32'd0);
    chk("rst2 irq",          32'(irq),          32'd0);
    rd(2'd0, r); chk("rst2 ctrl", r, 32'h0);
    rd(2'd1, r); chk("rst2 period", r, 32'd4999999);
    rd(2'd2, r); chk("rst2 pattern", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sq.delete();
    repeat (20) @(negedge clk);
    chk("rst2 no strobe", 32'(sq.size()), 32'd0);

    // DONE set and software clear in the same cycle: set wins
    wr(2'd1, 32'd0); wr(2'd2, 32'h1B);
    t = cyc;
    wr(2'd0, 32'h3);
    wait_to(t + 9);
    wr(2'd3, 32'h1);
    rd(2'd3, r); chk("race status", r, 32'h31);
    chk("race irq", 32'(irq), 32'd0);
    rd(2'd0, r); chk("race ctrl", r, 32'h2);
    wr(2'd3, 32'h1);
    rd(2'd3, r); chk("race clear", r, 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
